ym3438_pg_ctrl: RTL and testbench
=================================

Name: ym3438_pg_ctrl

Overview:
Sequencer and register front-end for the phase generator.
- Divides MCLK into the c1/c2 two-phase enables and runs the 24-slot operator counter.
- Holds the per-channel fnum/block registers, including channel-3 special mode, and the per-operator multi/dt registers.
- Presents the current slot's operands to the PG, one slot at a time.
- Turns key-on edges into the per-slot pg_reset phase-clear strobe.

Parameters:
- SLOTS, 24, operator slots per sample cycle.
- PRESC, 6, MCLK cycles per slot.

Ports:
- MCLK  in  1  single clock.
- IC  in  1  reset: one clock, synchronous, active-low.
- wr_valid  in  1  register write request.
- wr_ready  out  1  write accepted when wr_valid & wr_ready.
- wr_addr  in  9  bit8 = bank (1 selects channels 3-5); bits 7:0 = register number.
- wr_data  in  8  write data.
- c1  out  1  phase-1 enable.
- c2  out  1  phase-2 enable.
- slot  out  5  current slot index, 0-23.
- fnum  out  11  fnum for the current slot.
- block  out  3  block for the current slot.
- multi  out  4  multiplier for the current slot.
- dt  out  3  raw detune for the current slot; detune arithmetic is downstream.
- pg_reset  out  1  low = clear phase of the current slot.
- reg_21  out  8  test register.

Behaviour:
- Reset (IC=0 at a rising edge):
  - presc=0, slot=0.
  - All registers, key state and pending latches cleared.
  - Outputs during reset: c1=c2=0, wr_ready=0, pg_reset=0, all other outputs 0.
  - First edge with IC=1 starts presc at 0.
  - An IC assertion mid-slot or mid-write takes effect on that edge and discards any pending write.
- Prescaler:
  - presc counts 0..5 and wraps.
  - c1=1 when presc∈{0,1}; c2=1 when presc∈{3,4}. The phases never overlap.
  - Slot boundary is at presc==5: slot increments and wraps 23->0. One sample is 144 MCLK.
- Slot map:
  - Operator group by slot: 0-5 OP1, 6-11 OP3, 12-17 OP2, 18-23 OP4.
  - ch = slot mod 6; ch 0-2 are bank0, ch 3-5 are bank1.
  - Operand outputs (fnum, block, multi, dt, pg_reset) are registered at the boundary and held constant for the whole slot.
- Write handshake:
  - wr_ready=1 when idle.
  - On accept, the write is captured and wr_ready drops.
  - The write is applied at the next slot boundary. wr_ready returns to 1 on the cycle after that boundary.
  - At most one write is outstanding. Unknown addresses are accepted and ignored.
- Registers:
  - 0x21 (bank0): reg_21.
  - 0x27 bit6: ch3 special mode on. Any value other than 00 in bits 7:6 counts as on.
  - 0x28 key-on:
    - bits 2:0 select the channel: codes 0-2 -> ch 0-2, codes 4-6 -> ch 3-5; codes 3 and 7 are ignored.
    - bits 4/5/6/7 set the key state of OP1/OP2/OP3/OP4.
  - 0x30-0x3F dt/multi:
    - reg[1:0] = channel within the bank (3 ignored); reg[3:2] 0/1/2/3 = OP1/OP3/OP2/OP4.
    - data[6:4] = dt, data[3:0] = multi.
  - 0xA4-0xA6 and 0xAC-0xAE: write only a shared high latch, {block[2:0], fnum[10:8]} from data[5:0]. No visible change on their own.
  - 0xA0-0xA2: commit {latch, data} to channel fnum/block.
  - 0xA8-0xAA: commit {latch, data} to the ch3-special slots A8->OP3, A9->OP1, AA->OP2. These apply to bank0 channel 2 only.
- Channel-3 special mode: with mode on, the slots of ch 2 for OP1/OP2/OP3 use their special registers. OP4 always uses the normal ch 2 value.
- Key-on:
  - The per-slot prev-key bit is updated when that slot is presented.
  - pg_reset=0 for exactly one presentation of a slot whose key went 0->1; otherwise pg_reset=1.
  - Key-off and repeated key-on produce no strobe.
  - If a key-on write lands at the same boundary that presents its slot, the old key state is used; the strobe occurs on the next pass.

Decomposition:
- Shared package ym3438_pkg:
  - register address constants.
  - slot-to-operator table {OP1, OP3, OP2, OP4}.
  - SLOTS/PRESC constants.
  - fnum/block field widths.
- Natural sub-module ym3438_pg_ctrl_presc: prescaler plus slot counter, producing c1, c2, slot and the boundary strobe.

Test Plan:
1. Release IC -> c1 high at presc 0-1, c2 at 3-4; slot steps every 6 MCLK, 23->0 after 144 MCLK.
2. Write A4=0x22 -> ch0 slots unchanged; then A0=0x55 -> slots 0/6/12/18 show fnum=0x255, block=4.
3. Write 0x27=0x40, AD=0x13, A9=0x34 -> slot 2 shows fnum=0x334, block=2, while slot 20 keeps the A2/A6 value. Then 0x27=0x00 -> slot 2 reverts to the A2/A6 value.
4. Write 0x28=0xF1 -> pg_reset=0 once in slots 1/7/13/19 only; rewrite 0xF1 -> no strobe; 0x01 then 0xF1 -> strobes again.
5. Two back-to-back writes (0x31=0x57, 0x35=0x23) -> wr_ready low until the boundary; both applied: slot 1 multi=7 dt=5, slot 7 multi=3 dt=2.
6. IC low mid-slot with a write outstanding -> next edge: all outputs 0, write lost, slot=0.

Source files
------------

// File: rtl/ym3438_pkg.sv
// ym3438_pkg: shared definitions for the phase-generator control slice.
// Holds the sequencing constants, operand field widths, register address
// constants, the slot-to-operator table and small decode helpers used by
// ym3438_pg_ctrl and ym3438_pg_ctrl_presc.
package ym3438_pkg;

    localparam int SLOTS   = 24;
    localparam int PRESC   = 6;
    localparam int FNUM_W  = 11;
    localparam int BLOCK_W = 3;
    localparam int MULTI_W = 4;
    localparam int DT_W    = 3;

    localparam logic [7:0] REG_TEST    = 8'h21;
    localparam logic [7:0] REG_MODE    = 8'h27;
    localparam logic [7:0] REG_KEY     = 8'h28;
    localparam logic [7:0] REG_DTML    = 8'h30;
    localparam logic [7:0] REG_FNUM    = 8'hA0;
    localparam logic [7:0] REG_FLATCH  = 8'hA4;
    localparam logic [7:0] REG_SPNUM   = 8'hA8;
    localparam logic [7:0] REG_SPLATCH = 8'hAC;

    // Operator index doubles as the key-on bit position (data bit 4 + op).
    typedef enum logic [1:0] {
        OP1 = 2'd0,
        OP2 = 2'd1,
        OP3 = 2'd2,
        OP4 = 2'd3
    } op_e;

    typedef enum logic {
        WR_IDLE = 1'b0,
        WR_PEND = 1'b1
    } wr_state_e;

    typedef enum logic [2:0] {
        RK_NONE  = 3'd0,
        RK_TEST  = 3'd1,
        RK_MODE  = 3'd2,
        RK_KEY   = 3'd3,
        RK_DTML  = 3'd4,
        RK_FNUM  = 3'd5,
        RK_LATCH = 3'd6,
        RK_SPNUM = 3'd7
    } reg_kind_e;

    // Slot groups run OP1, OP3, OP2, OP4; the dt/multi reg[3:2] field uses
    // the same group order, so those registers are stored by group.
    function automatic op_e grp_op(input logic [1:0] grp);
        op_e op;
        case (grp)
            2'd0:    op = OP1;
            2'd1:    op = OP3;
            2'd2:    op = OP2;
            default: op = OP4;
        endcase
        return op;
    endfunction

    function automatic logic [1:0] slot_grp(input logic [4:0] s);
        logic [1:0] g;
        if (s < 5'd6) g = 2'd0;
        else if (s < 5'd12) g = 2'd1;
        else if (s < 5'd18) g = 2'd2;
        else g = 2'd3;
        return g;
    endfunction

    function automatic logic [2:0] slot_ch(input logic [4:0] s);
        logic [4:0] off;
        logic [4:0] diff;
        case (slot_grp(s))
            2'd0:    off = 5'd0;
            2'd1:    off = 5'd6;
            2'd2:    off = 5'd12;
            default: off = 5'd18;
        endcase
        diff = s - off;
        return diff[2:0];
    endfunction

    // Special-register index: A8 (0) feeds OP3, A9 (1) OP1, AA (2) OP2.
    function automatic logic [1:0] sp_index(input logic [1:0] grp);
        logic [1:0] idx;
        case (grp)
            2'd0:    idx = 2'd1;
            2'd1:    idx = 2'd0;
            2'd2:    idx = 2'd2;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    // Channel field 3 is never a channel, so it is filtered before the
    // per-channel register ranges are matched.
    function automatic reg_kind_e decode_reg(input logic [8:0] addr);
        reg_kind_e k;
        if (addr == {1'b0, REG_TEST}) k = RK_TEST;
        else if (addr == {1'b0, REG_MODE}) k = RK_MODE;
        else if (addr == {1'b0, REG_KEY}) k = RK_KEY;
        else if (addr[1:0] == 2'd3) k = RK_NONE;
        else if (addr[7:4] == REG_DTML[7:4]) k = RK_DTML;
        else if (addr[7:2] == REG_FNUM[7:2]) k = RK_FNUM;
        else if (addr[7:2] == REG_FLATCH[7:2]) k = RK_LATCH;
        else if (addr[7:2] == REG_SPLATCH[7:2]) k = RK_LATCH;
        else if ((addr[8] == 1'b0) && (addr[7:2] == REG_SPNUM[7:2])) k = RK_SPNUM;
        else k = RK_NONE;
        return k;
    endfunction

endpackage

// File: rtl/ym3438_pg_ctrl_presc.sv
// ym3438_pg_ctrl_presc: MCLK prescaler and operator slot counter.
// Ports:
//   MCLK     - clock
//   IC       - synchronous active-low reset
//   c1, c2   - registered two-phase enables (presc 0-1 and 3-4)
//   slot     - registered slot index 0-23
//   bnd      - high when the coming MCLK edge is a slot boundary
//   slot_nxt - slot index that the coming boundary will present
module ym3438_pg_ctrl_presc
    import ym3438_pkg::*;
(
    input  logic       MCLK,
    input  logic       IC,
    output logic       c1,
    output logic       c2,
    output logic [4:0] slot,
    output logic       bnd,
    output logic [4:0] slot_nxt
);

    localparam logic [2:0] PRESC_LAST = 3'(PRESC - 1);
    localparam logic [4:0] SLOT_LAST  = 5'(SLOTS - 1);

    logic [2:0] presc_r;
    logic [4:0] slot_r;
    logic       run_r;
    logic       c1_r;
    logic       c2_r;
    logic [2:0] presc_nxt_s;
    logic [4:0] slot_nxt_s;
    logic       bnd_s;

    // Next prescaler/slot state; the first edge after reset release counts
    // as a boundary so slot 0 gets presented with presc starting at 0.
    always_comb begin
        bnd_s       = 1'b0;
        presc_nxt_s = presc_r;
        slot_nxt_s  = slot_r;
        if (!run_r) begin
            bnd_s       = 1'b1;
            presc_nxt_s = 3'd0;
            slot_nxt_s  = 5'd0;
        end else if (presc_r == PRESC_LAST) begin
            bnd_s       = 1'b1;
            presc_nxt_s = 3'd0;
            slot_nxt_s  = (slot_r == SLOT_LAST) ? 5'd0 : slot_r + 5'd1;
        end else begin
            presc_nxt_s = presc_r + 3'd1;
        end
    end

    // Prescaler, slot counter and phase enables, registered from next state.
    always_ff @(posedge MCLK) begin
        if (!IC) begin
            presc_r <= 3'd0;
            slot_r  <= 5'd0;
            run_r   <= 1'b0;
            c1_r    <= 1'b0;
            c2_r    <= 1'b0;
        end else begin
            presc_r <= presc_nxt_s;
            slot_r  <= slot_nxt_s;
            run_r   <= 1'b1;
            c1_r    <= (presc_nxt_s == 3'd0) || (presc_nxt_s == 3'd1);
            c2_r    <= (presc_nxt_s == 3'd3) || (presc_nxt_s == 3'd4);
        end
    end

    assign c1       = c1_r;
    assign c2       = c2_r;
    assign slot     = slot_r;
    assign bnd      = bnd_s;
    assign slot_nxt = slot_nxt_s;

endmodule

// File: rtl/ym3438_pg_ctrl.sv
// ym3438_pg_ctrl: sequencer and register front-end for the phase generator.
// Ports:
//   MCLK, IC           - clock and synchronous active-low reset
//   wr_valid/wr_ready  - one-outstanding register write handshake
//   wr_addr, wr_data   - bank+register number and write data
//   c1, c2, slot       - phase enables and current slot
//   fnum, block, multi, dt - current slot's operands, held for the slot
//   pg_reset           - low for one presentation after a key-on edge
//   reg_21             - test register
module ym3438_pg_ctrl
    import ym3438_pkg::*;
(
    input  logic               MCLK,
    input  logic               IC,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [8:0]         wr_addr,
    input  logic [7:0]         wr_data,
    output logic               c1,
    output logic               c2,
    output logic [4:0]         slot,
    output logic [FNUM_W-1:0]  fnum,
    output logic [BLOCK_W-1:0] block,
    output logic [MULTI_W-1:0] multi,
    output logic [DT_W-1:0]    dt,
    output logic               pg_reset,
    output logic [7:0]         reg_21
);

    logic       bnd_s;
    logic [4:0] slot_nxt_s;

    ym3438_pg_ctrl_presc u_presc (
        .MCLK     (MCLK),
        .IC       (IC),
        .c1       (c1),
        .c2       (c2),
        .slot     (slot),
        .bnd      (bnd_s),
        .slot_nxt (slot_nxt_s)
    );

    wr_state_e          wr_state_r;
    logic               wr_ready_r;
    logic [8:0]         wr_addr_r;
    logic [7:0]         wr_data_r;
    logic [7:0]         reg_21_r;
    logic               mode_r;
    logic [5:0]         latch_r;
    logic [FNUM_W-1:0]  fnum_ch_r  [6];
    logic [BLOCK_W-1:0] block_ch_r [6];
    logic [FNUM_W-1:0]  fnum_sp_r  [3];
    logic [BLOCK_W-1:0] block_sp_r [3];
    logic [MULTI_W-1:0] multi_r    [6][4];
    logic [DT_W-1:0]    dt_r       [6][4];
    logic [3:0]         key_r      [6];
    logic [SLOTS-1:0]   prev_key_r;

    logic [FNUM_W-1:0]  fnum_r;
    logic [BLOCK_W-1:0] block_r;
    logic [MULTI_W-1:0] multi_r_o;
    logic [DT_W-1:0]    dt_r_o;
    logic               pg_reset_r;

    reg_kind_e          wr_kind_s;
    logic [2:0]         wr_ch_s;
    logic               key_ok_s;
    logic [2:0]         key_ch_s;

    // Decode of the captured write: bank 1 maps channel fields onto ch 3-5.
    always_comb begin
        wr_kind_s = decode_reg(wr_addr_r);
        wr_ch_s   = wr_addr_r[8] ? (3'd3 + {1'b0, wr_addr_r[1:0]}) : {1'b0, wr_addr_r[1:0]};
        key_ok_s  = (wr_data_r[1:0] != 2'd3);
        key_ch_s  = wr_data_r[2] ? (3'd3 + {1'b0, wr_data_r[1:0]}) : {1'b0, wr_data_r[1:0]};
    end

    // Write handshake FSM and register file; a captured write lands at the
    // next slot boundary and ready returns on the cycle after it.
    always_ff @(posedge MCLK) begin
        if (!IC) begin
            wr_state_r <= WR_IDLE;
            wr_ready_r <= 1'b0;
            wr_addr_r  <= 9'd0;
            wr_data_r  <= 8'd0;
            reg_21_r   <= 8'd0;
            mode_r     <= 1'b0;
            latch_r    <= 6'd0;
            for (int i = 0; i < 6; i++) begin
                fnum_ch_r[i]  <= 11'd0;
                block_ch_r[i] <= 3'd0;
                key_r[i]      <= 4'd0;
                for (int j = 0; j < 4; j++) begin
                    multi_r[i][j] <= 4'd0;
                    dt_r[i][j]    <= 3'd0;
                end
            end
            for (int i = 0; i < 3; i++) begin
                fnum_sp_r[i]  <= 11'd0;
                block_sp_r[i] <= 3'd0;
            end
        end else begin
            case (wr_state_r)
                WR_IDLE: begin
                    if (wr_valid && wr_ready_r) begin
                        wr_addr_r  <= wr_addr;
                        wr_data_r  <= wr_data;
                        wr_state_r <= WR_PEND;
                        wr_ready_r <= 1'b0;
                    end else begin
                        wr_ready_r <= 1'b1;
                    end
                end
                WR_PEND: begin
                    if (bnd_s) begin
                        wr_state_r <= WR_IDLE;
                        wr_ready_r <= 1'b1;
                        case (wr_kind_s)
                            RK_TEST:  reg_21_r <= wr_data_r;
                            RK_MODE:  mode_r   <= |wr_data_r[7:6];
                            RK_KEY: begin
                                if (key_ok_s) key_r[key_ch_s] <= wr_data_r[7:4];
                            end
                            RK_DTML: begin
                                dt_r[wr_ch_s][wr_addr_r[3:2]]    <= wr_data_r[6:4];
                                multi_r[wr_ch_s][wr_addr_r[3:2]] <= wr_data_r[3:0];
                            end
                            RK_FNUM: begin
                                fnum_ch_r[wr_ch_s]  <= {latch_r[2:0], wr_data_r};
                                block_ch_r[wr_ch_s] <= latch_r[5:3];
                            end
                            RK_LATCH: latch_r <= wr_data_r[5:0];
                            RK_SPNUM: begin
                                fnum_sp_r[wr_addr_r[1:0]]  <= {latch_r[2:0], wr_data_r};
                                block_sp_r[wr_addr_r[1:0]] <= latch_r[5:3];
                            end
                            default: wr_state_r <= WR_IDLE;
                        endcase
                    end else begin
                        wr_ready_r <= 1'b0;
                    end
                end
                default: begin
                    wr_state_r <= WR_IDLE;
                    wr_ready_r <= 1'b0;
                end
            endcase
        end
    end

    logic [2:0]         op_ch_s;
    logic [1:0]         op_grp_s;
    logic [1:0]         op_idx_s;
    logic [1:0]         sp_idx_s;
    logic               op_key_s;
    logic [FNUM_W-1:0]  fnum_sel_s;
    logic [BLOCK_W-1:0] block_sel_s;

    // Operand select for the slot about to be presented; ch 2 OP1-OP3 use
    // the special registers while special mode is on, OP4 never does.
    always_comb begin
        op_ch_s  = slot_ch(slot_nxt_s);
        op_grp_s = slot_grp(slot_nxt_s);
        op_idx_s = grp_op(op_grp_s);
        sp_idx_s = sp_index(op_grp_s);
        op_key_s = key_r[op_ch_s][op_idx_s];
        if (mode_r && (op_ch_s == 3'd2) && (op_grp_s != 2'd3)) begin
            fnum_sel_s  = fnum_sp_r[sp_idx_s];
            block_sel_s = block_sp_r[sp_idx_s];
        end else begin
            fnum_sel_s  = fnum_ch_r[op_ch_s];
            block_sel_s = block_ch_r[op_ch_s];
        end
    end

    // Operand registers and key-edge detection, updated only at boundaries.
    // Register writes landing on the same edge are not yet visible here.
    always_ff @(posedge MCLK) begin
        if (!IC) begin
            fnum_r     <= 11'd0;
            block_r    <= 3'd0;
            multi_r_o  <= 4'd0;
            dt_r_o     <= 3'd0;
            pg_reset_r <= 1'b0;
            prev_key_r <= 24'd0;
        end else if (bnd_s) begin
            fnum_r                 <= fnum_sel_s;
            block_r                <= block_sel_s;
            multi_r_o              <= multi_r[op_ch_s][op_grp_s];
            dt_r_o                 <= dt_r[op_ch_s][op_grp_s];
            pg_reset_r             <= !(op_key_s && !prev_key_r[slot_nxt_s]);
            prev_key_r[slot_nxt_s] <= op_key_s;
        end
    end

    assign wr_ready = wr_ready_r;
    assign fnum     = fnum_r;
    assign block    = block_r;
    assign multi    = multi_r_o;
    assign dt       = dt_r_o;
    assign pg_reset = pg_reset_r;
    assign reg_21   = reg_21_r;

endmodule

// File: tb/tb_ym3438_pg_ctrl.sv
// tb_ym3438_pg_ctrl: directed, table-driven bench for ym3438_pg_ctrl.
module tb_ym3438_pg_ctrl;

    logic        MCLK;
    logic        IC;
    logic        wr_valid;
    logic        wr_ready;
    logic [8:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        c1;
    logic        c2;
    logic [4:0]  slot;
    logic [10:0] fnum;
    logic [2:0]  block;
    logic [3:0]  multi;
    logic [2:0]  dt;
    logic        pg_reset;
    logic [7:0]  reg_21;

    int checks = 0;
    int errors = 0;
    int low_cnt [24];

    typedef struct {
        logic       wr;
        logic [8:0] addr;
        logic [7:0] data;
        logic       chk;
        int         slot;
        int         fnum;
        int         blk;
        int         multi;
        int         dt;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs [NV];

    ym3438_pg_ctrl dut (
        .MCLK     (MCLK),
        .IC       (IC),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .c1       (c1),
        .c2       (c2),
        .slot     (slot),
        .fnum     (fnum),
        .block    (block),
        .multi    (multi),
        .dt       (dt),
        .pg_reset (pg_reset),
        .reg_21   (reg_21)
    );

    initial MCLK = 1'b0;
    always #5 MCLK = ~MCLK;

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Wait for a fresh presentation of slot s (skipping one already showing).
    task automatic wait_slot(input int s);
        int n;
        n = 0;
        while ((int'(slot) == s) && (n < 20)) begin
            @(negedge MCLK);
            n++;
        end
        n = 0;
        while ((int'(slot) != s) && (n < 200)) begin
            @(negedge MCLK);
            n++;
        end
        chk("wait_slot", int'(slot), s);
    endtask

    task automatic check_ops(input string name, input int s, input int f, input int b,
                             input int m, input int d);
        wait_slot(s);
        chk({name, "_fnum"}, int'(fnum), f);
        chk({name, "_block"}, int'(block), b);
        chk({name, "_multi"}, int'(multi), m);
        chk({name, "_dt"}, int'(dt), d);
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!wr_ready && (n < 20)) begin
            @(negedge MCLK);
            n++;
        end
        chk("wr_ready_high", int'(wr_ready), 1);
    endtask

    task automatic do_write(input logic [8:0] a, input logic [7:0] d);
        wait_ready();
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        @(negedge MCLK);
        wr_valid = 1'b0;
        chk("wr_ready_drop", int'(wr_ready), 0);
        wait_ready();
    endtask

    // Count pg_reset-low cycles per slot over two samples; a strobed slot
    // is low for its whole 6-cycle presentation.
    task automatic key_window(input string name, input logic [23:0] mask);
        for (int s = 0; s < 24; s++) low_cnt[s] = 0;
        for (int c = 0; c < 300; c++) begin
            if (!pg_reset && (slot < 5'd24)) low_cnt[slot]++;
            @(negedge MCLK);
        end
        for (int s = 0; s < 24; s++)
            chk($sformatf("%s_slot%0d", name, s), low_cnt[s], mask[s] ? 6 : 0);
    endtask

    initial begin
        int s0;
        int n;

        vecs[0]  = '{1'b1, 9'h0A4, 8'h22, 1'b1, 0,  'h000, 0, 0, 0};
        vecs[1]  = '{1'b1, 9'h0A0, 8'h55, 1'b1, 0,  'h255, 4, 0, 0};
        vecs[2]  = '{1'b0, 9'h000, 8'h00, 1'b1, 6,  'h255, 4, 0, 0};
        vecs[3]  = '{1'b0, 9'h000, 8'h00, 1'b1, 12, 'h255, 4, 0, 0};
        vecs[4]  = '{1'b0, 9'h000, 8'h00, 1'b1, 18, 'h255, 4, 0, 0};
        vecs[5]  = '{1'b0, 9'h000, 8'h00, 1'b1, 3,  'h000, 0, 0, 0};
        vecs[6]  = '{1'b1, 9'h1A4, 8'h0F, 1'b0, 0,  0,     0, 0, 0};
        vecs[7]  = '{1'b1, 9'h1A1, 8'hAB, 1'b1, 4,  'h7AB, 1, 0, 0};
        vecs[8]  = '{1'b1, 9'h0A6, 8'h0A, 1'b0, 0,  0,     0, 0, 0};
        vecs[9]  = '{1'b1, 9'h0A2, 8'h11, 1'b1, 2,  'h211, 1, 0, 0};
        vecs[10] = '{1'b1, 9'h027, 8'h40, 1'b0, 0,  0,     0, 0, 0};
        vecs[11] = '{1'b1, 9'h0AD, 8'h13, 1'b0, 0,  0,     0, 0, 0};
        vecs[12] = '{1'b1, 9'h0A9, 8'h34, 1'b1, 2,  'h334, 2, 0, 0};
        vecs[13] = '{1'b0, 9'h000, 8'h00, 1'b1, 20, 'h211, 1, 0, 0};
        vecs[14] = '{1'b0, 9'h000, 8'h00, 1'b1, 14, 'h000, 0, 0, 0};
        vecs[15] = '{1'b1, 9'h027, 8'h00, 1'b1, 2,  'h211, 1, 0, 0};
        vecs[16] = '{1'b1, 9'h027, 8'h80, 1'b1, 2,  'h334, 2, 0, 0};
        vecs[17] = '{1'b1, 9'h027, 8'h00, 1'b1, 2,  'h211, 1, 0, 0};
        vecs[18] = '{1'b1, 9'h0FF, 8'hAA, 1'b0, 0,  0,     0, 0, 0};
        vecs[19] = '{1'b1, 9'h021, 8'h5A, 1'b0, 0,  0,     0, 0, 0};
        vecs[20] = '{1'b1, 9'h121, 8'h11, 1'b0, 0,  0,     0, 0, 0};

        IC       = 1'b0;
        wr_valid = 1'b0;
        wr_addr  = 9'h000;
        wr_data  = 8'h00;
        repeat (3) @(negedge MCLK);

        chk("rst_c1", int'(c1), 0);
        chk("rst_c2", int'(c2), 0);
        chk("rst_wr_ready", int'(wr_ready), 0);
        chk("rst_pg_reset", int'(pg_reset), 0);
        chk("rst_slot", int'(slot), 0);
        chk("rst_fnum", int'(fnum), 0);
        chk("rst_reg_21", int'(reg_21), 0);

        // Phase enables and slot stepping against a cycle-count model.
        IC = 1'b1;
        @(negedge MCLK);
        chk("start_wr_ready", int'(wr_ready), 1);
        chk("start_pg_reset", int'(pg_reset), 1);
        for (int cyc = 0; cyc < 150; cyc++) begin
            chk($sformatf("c1_cyc%0d", cyc), int'(c1), ((cyc % 6) < 2) ? 1 : 0);
            chk($sformatf("c2_cyc%0d", cyc), int'(c2), (((cyc % 6) == 3) || ((cyc % 6) == 4)) ? 1 : 0);
            chk($sformatf("slot_cyc%0d", cyc), int'(slot), (cyc / 6) % 24);
            @(negedge MCLK);
        end

        // Register write/readback vectors.
        for (int i = 0; i < NV; i++) begin
            if (vecs[i].wr) do_write(vecs[i].addr, vecs[i].data);
            if (vecs[i].chk)
                check_ops($sformatf("vec%0d", i), vecs[i].slot, vecs[i].fnum,
                          vecs[i].blk, vecs[i].multi, vecs[i].dt);
        end
        chk("reg_21_bank0_only", int'(reg_21), 'h5A);

        // Key-on edge strobes.
        do_write(9'h028, 8'hF3);
        key_window("key_code3", 24'h000000);
        do_write(9'h028, 8'hF1);
        key_window("key_on_ch1", 24'h082082);
        do_write(9'h028, 8'hF1);
        key_window("key_repeat", 24'h000000);
        do_write(9'h028, 8'h01);
        key_window("key_off", 24'h000000);
        do_write(9'h028, 8'hF1);
        key_window("key_on_again", 24'h082082);
        do_write(9'h028, 8'h16);
        key_window("key_ch5_op1", 24'h000020);

        // Back-to-back writes: the second waits for the first's boundary.
        wait_ready();
        wr_valid = 1'b1;
        wr_addr  = 9'h031;
        wr_data  = 8'h57;
        @(negedge MCLK);
        chk("b2b_first_accept", int'(wr_ready), 0);
        s0 = int'(slot);
        wr_addr = 9'h035;
        wr_data = 8'h23;
        n = 0;
        while (!wr_ready && (n < 10)) begin
            @(negedge MCLK);
            n++;
        end
        chk("b2b_wait_in_range", ((n >= 1) && (n <= 6)) ? 1 : 0, 1);
        chk("b2b_ready_after_boundary", int'(slot), (s0 + 1) % 24);
        @(negedge MCLK);
        wr_valid = 1'b0;
        chk("b2b_second_accept", int'(wr_ready), 0);
        wait_ready();
        check_ops("b2b_slot1", 1, 0, 0, 7, 5);
        check_ops("b2b_slot7", 7, 0, 0, 3, 2);

        // Reset mid-slot with a write outstanding.
        wait_ready();
        n = 0;
        while (!c2 && (n < 10)) begin
            @(negedge MCLK);
            n++;
        end
        wr_valid = 1'b1;
        wr_addr  = 9'h032;
        wr_data  = 8'h7F;
        @(negedge MCLK);
        wr_valid = 1'b0;
        chk("ic_write_pending", int'(wr_ready), 0);
        IC = 1'b0;
        @(negedge MCLK);
        chk("ic_c1", int'(c1), 0);
        chk("ic_c2", int'(c2), 0);
        chk("ic_wr_ready", int'(wr_ready), 0);
        chk("ic_pg_reset", int'(pg_reset), 0);
        chk("ic_slot", int'(slot), 0);
        chk("ic_fnum", int'(fnum), 0);
        chk("ic_block", int'(block), 0);
        chk("ic_multi", int'(multi), 0);
        chk("ic_dt", int'(dt), 0);
        chk("ic_reg_21", int'(reg_21), 0);
        IC = 1'b1;
        @(negedge MCLK);
        check_ops("post_ic_slot0", 0, 0, 0, 0, 0);
        check_ops("post_ic_slot1", 1, 0, 0, 0, 0);
        check_ops("post_ic_slot2", 2, 0, 0, 0, 0);
        check_ops("post_ic_slot4", 4, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
